// File: rtl/covariance_accumulator.sv
// Window accumulator for per-stock returns: gathers sums and cross-products over
// 2**LOG2_SAMPLES samples, then emits the sample covariance matrix with a start pulse.
module covariance_accumulator #(
    parameter int WIDTH        = 16,
    parameter int N_STOCKS     = 4,
    parameter int LOG2_SAMPLES = 4,
    parameter int FRAC         = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_valid_i,
    output logic                                sample_ready_o,
    input  logic [N_STOCKS*WIDTH-1:0]           sample_i,
    input  logic                                ds_ready_i,
    output logic                                start_o,
    output logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  matrix_o,
    output logic                                busy_o
);

    localparam int NTRI  = N_STOCKS * (N_STOCKS + 1) / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int SXW   = WIDTH + LOG2_SAMPLES;
    localparam int SXYW  = 2 * WIDTH + LOG2_SAMPLES;
    localparam int PRODW = 2 * SXW;
    localparam int CALCW = PRODW + 2;
    localparam int IDXW  = $clog2(NTRI + 1);
    localparam int RCW   = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;

    localparam logic signed [CALCW-1:0] SAT_MAX = CALCW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [CALCW-1:0] SAT_MIN = CALCW'(-(1 << (WIDTH - 1)));

    typedef enum logic [1:0] {ACC, FIN, PUB} state_t;

    // Upper-triangle (r<=c) entries are packed row-major, matching the FIN visit order.
    function automatic int triIdx(input int r, input int c);
        return r * N_STOCKS - (r * (r - 1)) / 2 + (c - r);
    endfunction

    state_t                   state_q, state_d;
    logic [LOG2_SAMPLES-1:0]  count_q, count_d;
    logic [IDXW-1:0]          entryIdx_q, entryIdx_d;
    logic [RCW-1:0]           row_q, row_d;
    logic [RCW-1:0]           col_q, col_d;
    logic                     start_q, start_d;
    logic signed [SXW-1:0]    sumX_q   [N_STOCKS];
    logic signed [SXW-1:0]    sumX_d   [N_STOCKS];
    logic signed [SXYW-1:0]   sumXY_q  [NTRI];
    logic signed [SXYW-1:0]   sumXY_d  [NTRI];
    logic signed [WIDTH-1:0]  matrix_q [N_STOCKS*N_STOCKS];
    logic signed [WIDTH-1:0]  matrix_d [N_STOCKS*N_STOCKS];

    logic signed [WIDTH-1:0]  x [N_STOCKS];
    logic signed [PRODW-1:0]  crossProd;
    logic signed [CALCW-1:0]  centered;
    logic signed [CALCW-1:0]  scaled;
    logic signed [WIDTH-1:0]  entryVal;

    always_comb begin
        for (int k = 0; k < N_STOCKS; k++) begin
            x[k] = sample_i[k*WIDTH +: WIDTH];
        end
    end

    // Mean removal and rescale for the entry selected by row_q/col_q, done at full precision.
    always_comb begin
        crossProd = PRODW'(sumX_q[row_q]) * PRODW'(sumX_q[col_q]);
        centered  = CALCW'(sumXY_q[entryIdx_q]) - CALCW'(crossProd >>> LOG2_SAMPLES);
        scaled    = centered >>> (LOG2_SAMPLES + FRAC);
        if (scaled > SAT_MAX) begin
            entryVal = SAT_MAX[WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            entryVal = SAT_MIN[WIDTH-1:0];
        end else begin
            entryVal = scaled[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        entryIdx_d     = entryIdx_q;
        row_d          = row_q;
        col_d          = col_q;
        start_d        = 1'b0;
        sumX_d         = sumX_q;
        sumXY_d        = sumXY_q;
        matrix_d       = matrix_q;
        sample_ready_o = 1'b0;
        busy_o         = 1'b0;

        unique case (state_q)
            ACC: begin
                sample_ready_o = 1'b1;
                if (sample_valid_i) begin
                    for (int k = 0; k < N_STOCKS; k++) begin
                        sumX_d[k] = sumX_q[k] + SXW'(x[k]);
                    end
                    for (int r = 0; r < N_STOCKS; r++) begin
                        for (int c = r; c < N_STOCKS; c++) begin
                            sumXY_d[triIdx(r, c)] = sumXY_q[triIdx(r, c)]
                                                  + SXYW'(PW'(x[r]) * PW'(x[c]));
                        end
                    end
                    if (count_q == {LOG2_SAMPLES{1'b1}}) begin
                        state_d    = FIN;
                        count_d    = '0;
                        entryIdx_d = '0;
                        row_d      = '0;
                        col_d      = '0;
                    end else begin
                        count_d = count_q + LOG2_SAMPLES'(1);
                    end
                end
            end
            FIN: begin
                busy_o = 1'b1;
                matrix_d[int'(row_q) * N_STOCKS + int'(col_q)] = entryVal;
                matrix_d[int'(col_q) * N_STOCKS + int'(row_q)] = entryVal;
                if (entryIdx_q == IDXW'(NTRI - 1)) begin
                    state_d = PUB;
                    for (int k = 0; k < N_STOCKS; k++) begin
                        sumX_d[k] = '0;
                    end
                    for (int t = 0; t < NTRI; t++) begin
                        sumXY_d[t] = '0;
                    end
                end else begin
                    entryIdx_d = entryIdx_q + IDXW'(1);
                    if (col_q == RCW'(N_STOCKS - 1)) begin
                        row_d = row_q + RCW'(1);
                        col_d = row_q + RCW'(1);
                    end else begin
                        col_d = col_q + RCW'(1);
                    end
                end
            end
            PUB: begin
                busy_o = 1'b1;
                if (ds_ready_i) begin
                    start_d = 1'b1;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            count_q    <= '0;
            entryIdx_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            start_q    <= 1'b0;
            for (int k = 0; k < N_STOCKS; k++) begin
                sumX_q[k] <= '0;
            end
            for (int t = 0; t < NTRI; t++) begin
                sumXY_q[t] <= '0;
            end
            for (int m = 0; m < N_STOCKS * N_STOCKS; m++) begin
                matrix_q[m] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            entryIdx_q <= entryIdx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            start_q    <= start_d;
            sumX_q     <= sumX_d;
            sumXY_q    <= sumXY_d;
            matrix_q   <= matrix_d;
        end
    end

    assign start_o = start_q;

    always_comb begin
        matrix_o = '0;
        for (int m = 0; m < N_STOCKS * N_STOCKS; m++) begin
            matrix_o[m*WIDTH +: WIDTH] = matrix_q[m];
        end
    end

endmodule

// File: tb/tb_covariance_accumulator.sv
// Bench for covariance_accumulator: a window-level covariance model checked every cycle,
// plus literal expectations for the directed windows.
module tb_covariance_accumulator;

    localparam int W = 16;
    localparam int N = 4;
    localparam int S = 16;
    localparam int NTRI = N * (N + 1) / 2;

    logic                 clk;
    logic                 rst;
    logic                 sample_valid_i;
    logic                 sample_ready_o;
    logic [N*W-1:0]       sample_i;
    logic                 ds_ready_i;
    logic                 start_o;
    logic [N*N*W-1:0]     matrix_o;
    logic                 busy_o;

    covariance_accumulator #(
        .WIDTH(W), .N_STOCKS(N), .LOG2_SAMPLES(4), .FRAC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o),
        .sample_i(sample_i),
        .ds_ready_i(ds_ready_i),
        .start_o(start_o),
        .matrix_o(matrix_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount = 0;
    int cycleNum = 0;
    int lastXferCycle = 0;
    int startCycle = 0;

    always @(posedge clk) cycleNum++;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleNum);
        end
    endtask

    // Window model: keeps the raw samples and evaluates the covariance formula directly.
    longint win [S][N];
    int winCount = 0;
    int finLeft = 0;
    bit inPub = 0;
    bit expStart = 0;
    bit modelInit = 0;
    logic [N*N*W-1:0] expMatrixVec = '0;
    logic [N*N*W-1:0] pendingVec = '0;

    task automatic modelCovariance();
        longint sx [N];
        longint sxy;
        longint t;
        for (int k = 0; k < N; k++) begin
            sx[k] = 0;
            for (int i = 0; i < S; i++) sx[k] += win[i][k];
        end
        for (int r = 0; r < N; r++) begin
            for (int c = r; c < N; c++) begin
                sxy = 0;
                for (int i = 0; i < S; i++) sxy += win[i][r] * win[i][c];
                t = (sxy - ((sx[r] * sx[c]) >>> 4)) >>> 12;
                if (t > 32767) t = 32767;
                if (t < -32768) t = -32768;
                pendingVec[(r*N+c)*W +: W] = 16'(t);
                pendingVec[(c*N+r)*W +: W] = 16'(t);
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            winCount = 0;
            finLeft = 0;
            inPub = 0;
            expStart = 0;
            expMatrixVec = '0;
            modelInit = 1;
        end else begin
            expStart = 0;
            if (finLeft > 0) begin
                finLeft--;
                if (finLeft == 0) begin
                    inPub = 1;
                    expMatrixVec = pendingVec;
                end
            end else if (inPub) begin
                if (ds_ready_i) begin
                    inPub = 0;
                    expStart = 1;
                end
            end else if (sample_valid_i) begin
                for (int k = 0; k < N; k++) win[winCount][k] = longint'($signed(sample_i[k*W +: W]));
                winCount++;
                if (winCount == S) begin
                    modelCovariance();
                    winCount = 0;
                    finLeft = NTRI;
                end
            end
        end
    end

    // Matrix is only pinned outside the window where entries are being rewritten.
    always @(negedge clk) begin
        if (modelInit) begin
            checkOutput("ready", sample_ready_o, !(finLeft > 0 || inPub));
            checkOutput("busy", busy_o, (finLeft > 0 || inPub));
            checkOutput("start", start_o, expStart);
            if (finLeft == 0) checkOutput("matrix", matrix_o, expMatrixVec);
        end
    end

    function automatic int sampleValue(input int p, input int i, input int k);
        int alt;
        alt = (i % 2 == 0) ? 1 : -1;
        case (p)
            0: return 0;
            1: return (k == 0) ? 256 * alt : 0;
            2: return (k < 2) ? 256 * alt : 0;
            3: return 512;
            4: return (k == 0) ? 32512 * alt : 0;
            default: return ((i * 37 + k * 53) % 200 - 100) * 3 + k * 64;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the final transfer edge.
    task automatic applyStimulus(input int pattern, input bit gaps);
        int waitCycles;
        for (int i = 0; i < S; i++) begin
            for (int k = 0; k < N; k++) sample_i[k*W +: W] = 16'(sampleValue(pattern, i, k));
            sample_valid_i = 1'b1;
            waitCycles = 0;
            @(negedge clk);
            while (!sample_ready_o && waitCycles < 100) begin
                @(negedge clk);
                waitCycles++;
            end
            if (!sample_ready_o) checkOutput("xferTimeout", sample_ready_o, 1);
            lastXferCycle = cycleNum;
            @(posedge clk);
            #1;
            sample_valid_i = 1'b0;
            if (gaps && (i % 3 == 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitStart();
        startCycle = -1;
        for (int n = 0; n < 40 && startCycle < 0; n++) begin
            @(negedge clk);
            if (start_o) startCycle = cycleNum;
        end
        if (startCycle < 0) checkOutput("startTimeout", start_o, 1);
    endtask

    task automatic runWindow(input int pattern, input bit gaps);
        applyStimulus(pattern, gaps);
        waitStart();
        @(posedge clk);
        #1;
    endtask

    int startSeen;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sample_valid_i = 1'b0;
        sample_i = '0;
        ds_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("rstMatrix", matrix_o, 0);
        checkOutput("rstReady", sample_ready_o, 1);
        checkOutput("rstBusy", busy_o, 0);
        checkOutput("rstStart", start_o, 0);
        @(posedge clk);
        #1;

        $display("[TB] all-zero window");
        runWindow(0, 0);
        checkOutput("zeroLatency", startCycle - lastXferCycle, 12);
        checkOutput("zeroMatrix", matrix_o, 0);

        $display("[TB] stock0 alternating +/-1.0");
        runWindow(1, 0);
        for (int i = 0; i < N * N; i++) checkOutput("altEntry", matrix_o[i*W +: W], (i == 0) ? 16'd256 : 16'd0);

        $display("[TB] stock0 == stock1 alternating");
        runWindow(2, 0);
        for (int i = 0; i < N * N; i++)
            checkOutput("pairEntry", matrix_o[i*W +: W], (i == 0 || i == 1 || i == 4 || i == 5) ? 16'd256 : 16'd0);

        $display("[TB] constant offset");
        runWindow(3, 1);
        checkOutput("constMatrix", matrix_o, 0);

        $display("[TB] saturation");
        runWindow(4, 0);
        checkOutput("satEntry0", matrix_o[0 +: W], 16'h7fff);
        checkOutput("satEntry1", matrix_o[W +: W], 16'h0000);
        checkOutput("satLatency", startCycle - lastXferCycle, 12);

        $display("[TB] ds_ready held low in publish");
        ds_ready_i = 1'b0;
        applyStimulus(5, 1);
        repeat (NTRI) @(posedge clk);
        #1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checkOutput("holdReady", sample_ready_o, 0);
            checkOutput("holdBusy", busy_o, 1);
            checkOutput("holdStart", start_o, 0);
            @(posedge clk);
            #1;
        end
        ds_ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("releaseStart", start_o, 1);
        @(posedge clk);
        #1;

        $display("[TB] reset at FIN entry 3");
        applyStimulus(1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midRstMatrix", matrix_o, 0);
        checkOutput("midRstReady", sample_ready_o, 1);
        checkOutput("midRstBusy", busy_o, 0);
        startSeen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (start_o) startSeen++;
        end
        checkOutput("midRstNoStart", startSeen, 0);
        @(posedge clk);
        #1;

        $display("[TB] window after mid-FIN reset");
        runWindow(1, 0);
        checkOutput("recoverEntry0", matrix_o[0 +: W], 16'd256);
        checkOutput("recoverLatency", startCycle - lastXferCycle, 12);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
